// File: rtl/sine_capture.sv
// sine_capture: receive-side capture block for one SineGen channel.
//
// Captures one full table of 2**depth_p samples from a SineGen channel into internal RAM
// while i_start is high. It signals done once the table is full and offers a registered
// random-access read port for checking or DMA.
//
// Parameters:
//   depth_p    - log2 of capture depth; the RAM holds 2**depth_p samples
//   width_p    - sample width in bits
//   trig_delay - cycles from i_freq_trig until the sample is valid on i_sine_in (0 or 1)
//
// Ports:
//   i_clk          - system clock, rising edge
//   i_reset        - synchronous active-high reset
//   i_start        - capture enable level; rising arms, low aborts or releases
//   i_freq_trig    - one-cycle sample strobe from SineGen
//   i_sine_in      - sample bus from SineGen
//   o_busy         - high while capturing
//   o_done         - high while the table is full
//   o_sample_count - samples written in the current or last capture
//   i_rd_en        - read request
//   i_rd_addr      - read address
//   o_rd_data      - registered read data (holds when no read)
//   o_rd_valid     - high the cycle after i_rd_en
//   o_min_val      - signed minimum of the capture (SINE_CAPTURE_MINMAX_EN only)
//   o_max_val      - signed maximum of the capture (SINE_CAPTURE_MINMAX_EN only)
//
// Optional feature macro: SINE_CAPTURE_MINMAX_EN adds the min/max tracking outputs.

module sine_capture #(
    parameter int unsigned depth_p    = 11,
    parameter int unsigned width_p    = 16,
    parameter int unsigned trig_delay = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_freq_trig,
    input  logic [width_p-1:0] i_sine_in,
    output logic               o_busy,
    output logic               o_done,
    output logic [depth_p:0]   o_sample_count,
    input  logic               i_rd_en,
    input  logic [depth_p-1:0] i_rd_addr,
`ifdef SINE_CAPTURE_MINMAX_EN
    output logic [width_p-1:0] o_min_val,
    output logic [width_p-1:0] o_max_val,
`endif
    output logic [width_p-1:0] o_rd_data,
    output logic               o_rd_valid
);

    localparam int unsigned Depth = 2 ** depth_p;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [depth_p-1:0] r_wr_ptr;
    logic [depth_p:0]   r_count;
    logic [width_p-1:0] r_mem [Depth];
    logic [width_p-1:0] r_rd_data;
    logic               r_rd_valid;

    logic w_arm;
    logic w_trig_qual;
    logic w_wr_en;
    logic w_last_wr;

    assign w_arm = (r_state == StIdle) && i_start;

    // The state check happens at trigger time. A trigger in the cycle that aborts
    // (start already low) is dropped so nothing is written after leaving capture.
    assign w_trig_qual = i_freq_trig && i_start && (r_state == StCapture);

    // Final write: the count is one short of the table size.
    assign w_last_wr = w_wr_en && (r_count == {1'b0, {depth_p{1'b1}}});

    generate
        if (trig_delay == 0) begin : g_trig_nodly
            assign w_wr_en = w_trig_qual;
        end else begin : g_trig_dly
            logic r_trig;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_trig <= 1'b0;
                end else begin
                    r_trig <= w_trig_qual;
                end
            end

            // A delayed write only lands while still capturing; a trigger seen on the
            // final-write cycle is thereby discarded once the state reaches DONE.
            assign w_wr_en = r_trig && (r_state == StCapture);
        end
    endgenerate

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StCapture;
                end
            end
            StCapture: begin
                if (!i_start) begin
                    w_state_next = StIdle;
                end else if (w_last_wr) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (!i_start) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write pointer and sample count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_arm) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr_en) begin
            // Pointer wraps to 0 on the final write; unused until the next arm.
            r_wr_ptr <= r_wr_ptr + depth_p'(1);
            r_count  <= r_count + (depth_p + 1)'(1);
        end
    end

    // Capture RAM; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_sine_in;
        end
    end

    // Registered read port; same-address read/write returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

`ifdef SINE_CAPTURE_MINMAX_EN
    logic               r_first;
    logic [width_p-1:0] r_min;
    logic [width_p-1:0] r_max;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_first <= 1'b0;
            r_min   <= '0;
            r_max   <= '0;
        end else if (w_arm) begin
            r_first <= 1'b1;
        end else if (w_wr_en) begin
            if (r_first) begin
                r_first <= 1'b0;
                r_min   <= i_sine_in;
                r_max   <= i_sine_in;
            end else begin
                if ($signed(i_sine_in) < $signed(r_min)) begin
                    r_min <= i_sine_in;
                end
                if ($signed(i_sine_in) > $signed(r_max)) begin
                    r_max <= i_sine_in;
                end
            end
        end
    end

    assign o_min_val = r_min;
    assign o_max_val = r_max;
`endif

    assign o_busy         = (r_state == StCapture);
    assign o_done         = (r_state == StDone);
    assign o_sample_count = r_count;
    assign o_rd_data      = r_rd_data;
    assign o_rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_sine_capture.sv
// Directed self-checking bench for sine_capture with depth_p=4, trig_delay=1.

module tb_sine_capture;

    localparam int unsigned DepthP = 4;
    localparam int unsigned WidthP = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic              freq_trig;
    logic [WidthP-1:0] sine_in;
    logic              busy;
    logic              done;
    logic [DepthP:0]   sample_count;
    logic              rd_en;
    logic [DepthP-1:0] rd_addr;
    logic [WidthP-1:0] rd_data;
    logic              rd_valid;
`ifdef SINE_CAPTURE_MINMAX_EN
    logic [WidthP-1:0] min_val;
    logic [WidthP-1:0] max_val;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sine_capture #(
        .depth_p    (DepthP),
        .width_p    (WidthP),
        .trig_delay (1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_freq_trig    (freq_trig),
        .i_sine_in      (sine_in),
        .o_busy         (busy),
        .o_done         (done),
        .o_sample_count (sample_count),
        .i_rd_en        (rd_en),
        .i_rd_addr      (rd_addr),
`ifdef SINE_CAPTURE_MINMAX_EN
        .o_min_val      (min_val),
        .o_max_val      (max_val),
`endif
        .o_rd_data      (rd_data),
        .o_rd_valid     (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DepthP-1:0] addr;
        logic [WidthP-1:0] exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger cycle (bus holds junk), then the sample is valid on the next cycle.
    task automatic do_write(input logic [WidthP-1:0] v);
        freq_trig = 1'b1;
        sine_in   = 16'hDEAD;
        tick();
        freq_trig = 1'b0;
        sine_in   = v;
        tick();
    endtask

    task automatic do_read(input logic [DepthP-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    logic [WidthP-1:0] mm_vals [16];

    initial begin
        // Readback table for the first capture, visited in reverse address order.
        for (int i = 0; i < 16; i++) begin
            rd_tab[i].addr     = 4'(15 - i);
            rd_tab[i].exp_data = 16'h0100 + 16'(15 - i);
        end
        mm_vals[0] = 16'h7FFF;
        mm_vals[1] = 16'h8000;
        mm_vals[2] = 16'h0000;
        for (int i = 3; i < 16; i++) begin
            mm_vals[i] = 16'h0111 * 16'(i - 2);
        end

        reset     = 1'b1;
        start     = 1'b1;
        freq_trig = 1'b0;
        sine_in   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;

        // Reset held with start high
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_count", 32'(sample_count), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
`ifdef SINE_CAPTURE_MINMAX_EN
        check("reset_min", 32'(min_val), 32'd0);
        check("reset_max", 32'(max_val), 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();

        // Spaced capture: one pulse every 4 cycles
        start = 1'b1;
        tick();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_count", 32'(sample_count), 32'd0);
        for (int k = 0; k < 16; k++) begin
            do_write(16'h0100 + 16'(k));
            if (k == 14) begin
                check("spaced_count15", 32'(sample_count), 32'd15);
                check("spaced_done_early", 32'(done), 32'd0);
            end
            if (k < 15) begin
                tick();
                tick();
            end
        end
        check("spaced_done", 32'(done), 32'd1);
        check("spaced_busy", 32'(busy), 32'd0);
        check("spaced_count", 32'(sample_count), 32'd16);

        for (int i = 0; i < 16; i++) begin
            do_read(rd_tab[i].addr);
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_spaced", 32'(rd_data), 32'(rd_tab[i].exp_data));
        end
        tick();
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'h0100);

        // Triggers in DONE are ignored
        freq_trig = 1'b1;
        sine_in   = 16'hBEEF;
        repeat (3) tick();
        freq_trig = 1'b0;
        tick();
        check("done_trig_count", 32'(sample_count), 32'd16);
        check("done_hold", 32'(done), 32'd1);
        do_read(4'd0);
        check("done_trig_ram", 32'(rd_data), 32'h0100);

        // Release to IDLE, then triggers in IDLE are ignored
        start = 1'b0;
        tick();
        check("release_done", 32'(done), 32'd0);
        check("release_busy", 32'(busy), 32'd0);
        check("release_count", 32'(sample_count), 32'd16);
        freq_trig = 1'b1;
        repeat (3) tick();
        freq_trig = 1'b0;
        tick();
        check("idle_trig_count", 32'(sample_count), 32'd16);
        do_read(4'd3);
        check("idle_trig_ram", 32'(rd_data), 32'h0103);

        // Back-to-back triggers; sample for trigger i is on the bus in cycle i+1
        start = 1'b1;
        tick();
        check("b2b_arm_count", 32'(sample_count), 32'd0);
        for (int i = 0; i < 18; i++) begin
            freq_trig = 1'b1;
            sine_in   = 16'h0200 + 16'(i);
            tick();
            if (i == 15) begin
                check("b2b_count15", 32'(sample_count), 32'd15);
                check("b2b_done_early", 32'(done), 32'd0);
            end
            if (i == 16) begin
                check("b2b_done", 32'(done), 32'd1);
                check("b2b_count16", 32'(sample_count), 32'd16);
            end
        end
        freq_trig = 1'b0;
        tick();
        check("b2b_no_overrun", 32'(sample_count), 32'd16);
        for (int k = 0; k < 16; k++) begin
            do_read(4'(k));
            check("rd_b2b", 32'(rd_data), 32'h0201 + 32'(k));
        end

        // Abort after 5 writes, with a trigger on the abort cycle
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("abort_arm_count", 32'(sample_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            do_write(16'h0300 + 16'(k));
        end
        check("abort_pre_count", 32'(sample_count), 32'd5);
        start     = 1'b0;
        freq_trig = 1'b1;
        tick();
        freq_trig = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(sample_count), 32'd5);
        tick();
        check("abort_count_hold", 32'(sample_count), 32'd5);
        do_read(4'd5);
        check("abort_dropped_trig", 32'(rd_data), 32'h0206);
        do_read(4'd4);
        check("abort_last_write", 32'(rd_data), 32'h0304);

        // Re-arm restarts the count
        start = 1'b1;
        tick();
        check("rearm_count", 32'(sample_count), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);

        // Read and write of address 0 in the same cycle returns the old word
        freq_trig = 1'b1;
        tick();
        freq_trig = 1'b0;
        sine_in   = 16'h0400;
        rd_en     = 1'b1;
        rd_addr   = 4'd0;
        tick();
        rd_en = 1'b0;
        check("rw_same_old", 32'(rd_data), 32'h0300);
        check("rw_same_count", 32'(sample_count), 32'd1);
        do_read(4'd0);
        check("rw_same_new", 32'(rd_data), 32'h0400);

        // Signed extremes capture
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            do_write(mm_vals[k]);
`ifdef SINE_CAPTURE_MINMAX_EN
            if (k == 0) begin
                check("mm_first_min", 32'(min_val), 32'h7FFF);
                check("mm_first_max", 32'(max_val), 32'h7FFF);
            end
`endif
        end
        check("mm_done", 32'(done), 32'd1);
        check("mm_count", 32'(sample_count), 32'd16);
        do_read(4'd1);
        check("mm_rd1", 32'(rd_data), 32'h8000);
`ifdef SINE_CAPTURE_MINMAX_EN
        check("mm_min", 32'(min_val), 32'h8000);
        check("mm_max", 32'(max_val), 32'h7FFF);
        start = 1'b0;
        tick();
        check("mm_min_hold", 32'(min_val), 32'h8000);
        check("mm_max_hold", 32'(max_val), 32'h7FFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_capture.md
Name: sine_capture

Overview:
- Receive-side companion to SineGen; consumes one SineGen channel (sine sample bus plus freq_trig strobe).
- Captures one full table of 2**depth_p samples into internal RAM, gated by a start level.
- Signals done when the table is full; gives random-access readback for checking or DMA.
- Replaces bench-side capture logic with a synthesizable block placed next to each SineGen channel.

Parameters:
- depth_p, 11, log2 of capture depth; RAM holds 2**depth_p samples.
- width_p, 16, sample width in bits; matches SineGen output width.
- trig_delay, 1, cycles between freq_trig and the sample being valid on sine_in; legal values 0 or 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  capture enable level; 0→1 arms, 0 aborts or releases.
- freq_trig  in  1  one-cycle sample strobe from SineGen.
- sine_in  in  width_p  sample bus from SineGen.
- busy  out  1  high while in CAPTURE.
- done  out  1  high while in DONE (table full).
- sample_count  out  depth_p+1  number of samples written in current or last capture.
- rd_en  in  1  read request.
- rd_addr  in  depth_p  read address.
- rd_data  out  width_p  registered read data.
- rd_valid  out  1  high the cycle after rd_en.

Behaviour:
- Reset, checked at posedge clk while reset=1:
  - state=IDLE; busy=0, done=0, sample_count=0, rd_data=0, rd_valid=0; trigger pipeline cleared.
  - RAM contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: start=1 → CAPTURE; wr_ptr=0 and sample_count=0 on the transition edge.
  - CAPTURE:
    - start=0 → IDLE (abort); sample_count keeps its value, done stays 0.
    - Writing the last sample (sample_count becomes 2**depth_p) → DONE.
  - DONE: hold done=1. start=0 → IDLE, done→0. start still 1 → stay in DONE; no auto-rearm.
- Write event:
  - A write event is freq_trig qualified by state==CAPTURE, delayed by trig_delay cycles.
  - trig_delay=1: freq_trig registered; the write happens on the next cycle using sine_in from that cycle.
  - trig_delay=0: sine_in is written on the freq_trig cycle itself.
  - The state check is done at trig time. A trig seen in the last CAPTURE cycle before abort is dropped; no write after leaving CAPTURE.
  - Each write event: RAM[wr_ptr] ← sine_in, wr_ptr+1, sample_count+1.
  - wr_ptr is depth_p bits. It wraps to 0 on the final write but is not used again until re-arm.
  - freq_trig on consecutive cycles gives consecutive writes; no throttling and no loss.
  - freq_trig in IDLE or DONE is ignored.
- Read port:
  - Available in every state.
  - rd_en at cycle N → rd_data=RAM[rd_addr] and rd_valid=1 at cycle N+1.
  - rd_valid=0 when rd_en=0; rd_data holds its last value.
  - Read and write to the same address in the same cycle is read-first (returns old data).
- Busy/done timing:
  - busy=1 exactly while state==CAPTURE.
  - done rises the cycle after the final write edge, i.e. registered with the state.
- Start re-pulse: start 1→0→1 with one cycle low from DONE → IDLE, then CAPTURE with a fresh count. Data from the prior capture is overwritten progressively.

Optional Feature:
- Macro: SINE_CAPTURE_MINMAX_EN.
- Defined:
  - Adds outputs min_val and max_val, each width_p bits, signed two's-complement compare.
  - Both are initialised from the first write of each capture, then updated on every write.
  - Reset value is 0; both hold after DONE or abort.
- Undefined: the ports and logic are absent and everything else is unchanged.

Test Plan:
- reset=1 for 3 cycles, start=1 → busy=0, done=0, sample_count=0, rd_valid=0.
- depth_p=4, trig_delay=1; start=1; 16 freq_trig pulses every 4 cycles with sine_in=16'h0100+k, k=0..15 → done=1 after the 16th write, sample_count=16, readback addr k gives 16'h0100+k.
- freq_trig held high for 16 consecutive cycles, sine_in = cycle index → all 16 stored in order, no gaps; done=1 one cycle after the last write.
- Abort: start dropped after 5 writes → IDLE, sample_count=5, done=0; re-arm → sample_count restarts at 0.
- freq_trig pulses in IDLE and DONE → no RAM change, sample_count unchanged; read and write same address same cycle returns old value.
- MINMAX_EN: samples 16'sh7FFF, 16'sh8000, 0, then 13 others → max_val=16'h7FFF, min_val=16'h8000.
